// File: rtl/noc_input_port.sv
// Router input port: credit-managed flit FIFO with XY route computation.
// Holds one output request per packet and returns a credit per dequeued flit.
module noc_input_port #(
    parameter int FLIT_W  = 20,
    parameter int DEPTH   = 8,
    parameter int COORD_W = 3,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        flit_in,
    input  logic                     flit_in_valid,
    output logic                     credit_out,
    output logic [FLIT_W-1:0]        flit_out,
    output logic                     flit_out_valid,
    output logic [4:0]               route_req,
    input  logic                     grant,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_seq,
    output logic                     err_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int XM = FLIT_W - 3;
    localparam int YM = XM - COORD_W;
    localparam logic [COORD_W-1:0] LX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] LY = COORD_W'(CUR_Y);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUTE,
        S_ACTIVE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic [4:0]        r_route;
    logic              r_credit;
    logic              r_err_seq;
    logic              r_err_ovf;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_seq;
    logic              w_drop;
    logic              w_look_head;
    logic [FLIT_W-1:0] w_head;
    logic [COORD_W:0]  w_xd;
    logic [COORD_W:0]  w_yd;
    logic [4:0]        w_route;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_head  = r_mem[r_rptr];

    // An empty FIFO lets IDLE judge the flit being written this edge.
    assign w_look_head = w_empty ? flit_in[FLIT_W-1] : w_head[FLIT_W-1];

    assign w_xd = {1'b0, w_head[XM -: COORD_W]} - {1'b0, LX};
    assign w_yd = {1'b0, w_head[YM -: COORD_W]} - {1'b0, LY};

    always_comb begin
        w_route = 5'b10000;
        if (w_xd != '0) begin
            w_route = w_xd[COORD_W] ? 5'b01000 : 5'b00010;
        end else if (w_yd != '0) begin
            w_route = w_yd[COORD_W] ? 5'b00100 : 5'b00001;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_pop          = 1'b0;
        w_seq          = 1'b0;
        flit_out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty || flit_in_valid) begin
                    if (w_look_head) begin
                        w_next = S_ROUTE;
                    end else begin
                        w_pop = 1'b1;
                        w_seq = 1'b1;
                    end
                end
            end
            S_ROUTE: w_next = S_ACTIVE;
            S_ACTIVE: begin
                flit_out_valid = !w_empty;
                w_pop          = !w_empty && grant;
                if (w_pop && w_head[FLIT_W-2]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_push = flit_in_valid && (!w_full || w_pop);
    assign w_drop = flit_in_valid && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= flit_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_route   <= '0;
            r_credit  <= 1'b0;
            r_err_seq <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_credit  <= w_pop;
            r_err_seq <= w_seq;
            r_err_ovf <= r_err_ovf | w_drop;
            r_count   <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (r_state == S_ROUTE) begin
                r_route <= w_route;
            end else if (r_state == S_ACTIVE && w_next == S_IDLE) begin
                r_route <= '0;
            end
        end
    end

    assign flit_out   = w_empty ? '0 : w_head;
    assign fifo_count = r_count;
    assign route_req  = r_route;
    assign credit_out = r_credit;
    assign err_seq    = r_err_seq;
    assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port: queue-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_noc_input_port;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [19:0] fin;
    logic        fin_v;
    logic        gnt;

    logic        cr1, fov1, es1, eo1;
    logic [19:0] fo1;
    logic [4:0]  rr1;
    logic [3:0]  fc1;
    logic        cr2, fov2, es2, eo2;
    logic [19:0] fo2;
    logic [4:0]  rr2;
    logic [3:0]  fc2;

    noc_input_port #(.CUR_X(0), .CUR_Y(0)) u1 (
        .clk(clk), .rst(rst), .flit_in(fin), .flit_in_valid(fin_v),
        .credit_out(cr1), .flit_out(fo1), .flit_out_valid(fov1),
        .route_req(rr1), .grant(gnt), .fifo_count(fc1),
        .err_seq(es1), .err_ovf(eo1)
    );

    noc_input_port #(.CUR_X(2), .CUR_Y(2)) u2 (
        .clk(clk), .rst(rst), .flit_in(fin), .flit_in_valid(fin_v),
        .credit_out(cr2), .flit_out(fo2), .flit_out_valid(fov2),
        .route_req(rr2), .grant(gnt), .fifo_count(fc2),
        .err_seq(es2), .err_ovf(eo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cred1   = 0;

    // Reference model: packet phase 0=idle, 1=routing, 2=forwarding
    logic [19:0] q[$];
    int          ph;
    logic [4:0]  mr0, mr2;
    logic        mcred, mseq, movf;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] xy(logic [19:0] f, int cx, int cy);
        int dx;
        int dy;
        dx = int'(f[17:15]);
        dy = int'(f[14:12]);
        if (dx > cx) return 5'b00010;
        if (dx < cx) return 5'b01000;
        if (dy > cy) return 5'b00001;
        if (dy < cy) return 5'b00100;
        return 5'b10000;
    endfunction

    task automatic model_reset();
        q.delete();
        ph    = 0;
        mr0   = '0;
        mr2   = '0;
        mcred = 1'b0;
        mseq  = 1'b0;
        movf  = 1'b0;
    endtask

    task automatic model_step();
        logic [19:0] look;
        logic        pop;
        logic        seq;
        logic        push;
        int          nph;
        pop = 1'b0;
        seq = 1'b0;
        nph = ph;
        if (ph == 0) begin
            if (q.size() > 0 || fin_v) begin
                look = (q.size() > 0) ? q[0] : fin;
                if (look[19]) nph = 1;
                else begin
                    pop = 1'b1;
                    seq = 1'b1;
                end
            end
        end else if (ph == 1) begin
            nph = 2;
            mr0 = xy(q[0], 0, 0);
            mr2 = xy(q[0], 2, 2);
        end else begin
            if (q.size() > 0 && gnt) begin
                pop = 1'b1;
                if (q[0][18]) begin
                    nph = 0;
                    mr0 = '0;
                    mr2 = '0;
                end
            end
        end
        push = fin_v && (q.size() < DEPTH || pop);
        if (fin_v && !push) movf = 1'b1;
        if (push) q.push_back(fin);
        if (pop) void'(q.pop_front());
        mcred = pop;
        mseq  = seq;
        ph    = nph;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) model_step();
        end
    end

    task automatic cmp_dut(string t, logic [3:0] fc, logic [19:0] fo,
                           logic fov, logic [4:0] rr, logic cr,
                           logic es, logic eo, logic [4:0] er);
        logic [19:0] ef;
        ef = (q.size() > 0) ? q[0] : 20'h0;
        chk({t, "_count"}, 32'(fc), 32'(q.size()));
        chk({t, "_flit"}, 32'(fo), 32'(ef));
        chk({t, "_valid"}, 32'(fov), 32'(ph == 2 && q.size() > 0));
        chk({t, "_route"}, 32'(rr), 32'(er));
        chk({t, "_credit"}, 32'(cr), 32'(mcred));
        chk({t, "_errseq"}, 32'(es), 32'(mseq));
        chk({t, "_errovf"}, 32'(eo), 32'(movf));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cred1 += int'(cr1);
            cmp_dut("u1", fc1, fo1, fov1, rr1, cr1, es1, eo1, mr0);
            cmp_dut("u2", fc2, fo2, fov2, rr2, cr2, es2, eo2, mr2);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [19:0] f);
        fin_v = v;
        fin   = f;
    endtask

    task automatic route_test(int x, int y, logic [4:0] e1, logic [4:0] e2);
        tick();
        drive(1'b1, {2'b11, 3'(x), 3'(y), 12'h5A5});
        tick();
        drive(1'b0, 20'h0);
        tick();
        chk("rt_u1", 32'(rr1), 32'(e1));
        chk("rt_u2", 32'(rr2), 32'(e2));
        chk("rt_model", 32'(mr2), 32'(e2));
        tick();
        tick();
    endtask

    task automatic zero_check(string t);
        chk({t, "_z_count"}, 32'(fc1), 0);
        chk({t, "_z_route"}, 32'(rr1), 0);
        chk({t, "_z_valid"}, 32'(fov1), 0);
        chk({t, "_z_flit"}, 32'(fo1), 0);
        chk({t, "_z_credit"}, 32'(cr1), 0);
        chk({t, "_z_errseq"}, 32'(es1), 0);
        chk({t, "_z_errovf"}, 32'(eo1), 0);
        chk({t, "_z_count2"}, 32'(fc2), 0);
    endtask

    initial begin
        int c0;
        int rem;
        int r;
        rst = 1'b0;
        gnt = 1'b0;
        drive(1'b0, 20'h0);
        model_reset();
        tick();
        tick();
        zero_check("reset");
        rst = 1'b1;
        tick();

        // single packet East
        gnt = 1'b1;
        c0  = cred1;
        drive(1'b1, 20'h88000);
        tick();
        drive(1'b1, 20'h00123);
        tick();
        chk("east_route", 32'(rr1), 32'h02);
        chk("east_model_route", 32'(mr0), 32'h02);
        chk("east_head", 32'(fo1), 32'h88000);
        chk("east_valid", 32'(fov1), 1);
        drive(1'b1, 20'h40456);
        tick();
        chk("east_body", 32'(fo1), 32'h00123);
        drive(1'b0, 20'h0);
        tick();
        chk("east_tail", 32'(fo1), 32'h40456);
        tick();
        chk("east_route_clr", 32'(rr1), 0);
        chk("east_count", 32'(fc1), 0);
        tick();
        chk("east_credits", 32'(cred1 - c0), 3);

        // routing matrix
        route_test(3, 0, 5'b00010, 5'b00010);
        route_test(1, 5, 5'b00010, 5'b01000);
        route_test(2, 3, 5'b00010, 5'b00001);
        route_test(2, 1, 5'b00010, 5'b00100);
        route_test(2, 2, 5'b00010, 5'b10000);
        route_test(0, 0, 5'b10000, 5'b01000);
        route_test(0, 5, 5'b00001, 5'b01000);

        // sequence error
        tick();
        c0 = cred1;
        drive(1'b1, 20'h00AAA);
        tick();
        drive(1'b0, 20'h0);
        chk("seq_err", 32'(es1), 1);
        chk("seq_credit", 32'(cr1), 1);
        chk("seq_route", 32'(rr1), 0);
        tick();
        chk("seq_err_pulse", 32'(es1), 0);
        chk("seq_credits", 32'(cred1 - c0), 1);
        route_test(1, 0, 5'b00010, 5'b01000);

        // full with simultaneous push and pop
        gnt = 1'b0;
        tick();
        drive(1'b1, 20'h88000);
        for (int i = 1; i < 8; i++) begin
            tick();
            drive(1'b1, 20'(i));
        end
        tick();
        chk("spp_full", 32'(fc1), 8);
        gnt = 1'b1;
        drive(1'b1, 20'h00B00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("spp_count", 32'(fc1), 8);
            chk("spp_ovf", 32'(eo1), 0);
            drive(1'b1, 20'(12'hB01 + i));
        end
        tick();
        drive(1'b1, 20'h40777);
        tick();
        drive(1'b0, 20'h0);
        repeat (12) tick();
        chk("spp_drain", 32'(fc1), 0);

        // backpressure and overflow
        gnt = 1'b0;
        c0  = cred1;
        drive(1'b1, 20'h90000);
        for (int i = 1; i < 7; i++) begin
            tick();
            drive(1'b1, 20'(12'hC00 + i));
        end
        tick();
        drive(1'b1, 20'h40C07);
        tick();
        chk("bp_count8", 32'(fc1), 8);
        chk("bp_no_ovf", 32'(eo1), 0);
        drive(1'b1, 20'h00999);
        tick();
        drive(1'b0, 20'h0);
        chk("bp_count", 32'(fc1), 8);
        chk("bp_ovf", 32'(eo1), 1);
        chk("bp_no_credit", 32'(cred1 - c0), 0);
        gnt = 1'b1;
        repeat (10) tick();
        chk("bp_credits", 32'(cred1 - c0), 8);
        chk("bp_empty", 32'(fc1), 0);
        chk("bp_ovf_sticky", 32'(eo1), 1);

        // reset mid-packet
        gnt = 1'b0;
        drive(1'b1, 20'h88000);
        tick();
        drive(1'b1, 20'h00321);
        tick();
        drive(1'b0, 20'h0);
        tick();
        chk("mid_count", 32'(fc1), 2);
        chk("mid_route", 32'(rr1), 32'h02);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        zero_check("midrst");
        tick();
        rst = 1'b1;
        gnt = 1'b1;
        route_test(0, 3, 5'b00001, 5'b01000);

        // randomized traffic
        rem = -1;
        repeat (3000) begin
            tick();
            gnt = ($urandom % 4) != 0;
            if (($urandom % 3) != 0) begin
                if (rem < 0) begin
                    r = int'($urandom % 10);
                    if (r == 0) begin
                        drive(1'b1, {2'b00, 18'($urandom)});
                    end else if (r < 4) begin
                        drive(1'b1, {2'b11, 18'($urandom)});
                    end else begin
                        drive(1'b1, {2'b10, 18'($urandom)});
                        rem = int'($urandom % 4);
                    end
                end else if (rem > 0) begin
                    drive(1'b1, {2'b00, 18'($urandom)});
                    rem--;
                end else begin
                    drive(1'b1, {2'b01, 18'($urandom)});
                    rem = -1;
                end
            end else begin
                drive(1'b0, 20'h0);
            end
        end
        drive(1'b0, 20'h0);
        gnt = 1'b1;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
